checksum_rx_ctrl: RTL
=====================

Name: checksum_rx_ctrl

Overview:
Framing and sequencing controller for the 48-bit ones'-complement checksum receiver datapath. It accepts a serial stream of 16-bit words over a valid/ready handshake and assembles WORDS words into one frame. It keeps a running end-around-carry sum and presents the assembled frame with a pass/fail flag to a downstream consumer over a second valid/ready handshake. It sits between the link word interface and the frame consumer, replacing the combinational whole-frame check with an incremental, flow-controlled one.

Parameters:
WIDTH, 16, word width in bits.
WORDS, 3, words per frame, including the final checksum word. Legal range 2..8.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  in_word is valid this cycle.
in_ready  out  1  controller can accept a word this cycle.
in_word  in  WIDTH  incoming word; the first word of a frame lands in the MSBs of out_data.
in_sof  in  1  start of frame, qualified by in_valid & in_ready.
out_valid  out  1  assembled frame available.
out_ready  in  1  consumer accepts the frame.
out_data  out  WORDS*WIDTH  assembled frame: word 0 in bits [WORDS*WIDTH-1 -: WIDTH].
out_ok  out  1  frame checksum good; valid only while out_valid=1.

Behaviour:
- Reset (async assert, held until deassert): state=IDLE, word count=0, sum=0, out_valid=0, out_ok=0, out_data=0, in_ready=1.
- Word transfer occurs when in_valid & in_ready. Frame transfer occurs when out_valid & out_ready.
- Running sum: s_next = (s + w) with end-around carry: the carry out of bit WIDTH-1 is added back into bit 0. Compute at WIDTH+1 bits and fold once; a single fold is sufficient.
- out_ok = (final folded sum == all ones, 16'hFFFF).
- States:
  - IDLE: in_ready=1. On a transfer, word becomes word 0, sum=word, count=1, go to COLLECT. in_sof is ignored in IDLE; any accepted word starts a frame.
  - COLLECT: in_ready=1.
    - Transfer with in_sof=1 is a resync: discard the partial frame, the word becomes word 0, count=1.
    - Transfer with in_sof=0: shift the word in, add it to sum, count+1.
    - When the accepted word is word WORDS-1: latch out_data and out_ok, set out_valid=1 on the next edge, go to HOLD.
  - HOLD: in_ready=0. out_data, out_ok and out_valid are stable until the frame transfer. On the transfer: out_valid=0, go to IDLE.
- No same-cycle bypass from HOLD to accepting a new word: in_ready rises on the cycle after the frame transfer.
- Latency: out_valid asserts 1 cycle after the final word transfer. Minimum frame period is WORDS+1 cycles with out_ready held high.
- in_word and in_sof are don't-care when in_valid=0.
- Reset asserted mid-frame or in HOLD: the frame is dropped and no out_valid pulse is produced.

Optional Feature:
Macro CHECKSUM_RX_CTRL_ERR_CNT_EN.
- Defined: adds output port err_cnt (out, 16). It is a saturating count of frames delivered with out_ok=0, incremented on the frame transfer, holding at 16'hFFFF. Resync discards are not counted. Reset value 0.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- Good frame: words 0x9D2D, 0xC3D5, 0x9EFC on consecutive cycles, out_ready=1 -> out_valid for one cycle, out_data=0x9D2DC3D59EFC, out_ok=1.
- Bad checksum: 0x9D2D, 0xC3D5, 0x9EFD -> out_ok=0 (folded sum 0x0001). Corrupt middle word: 0x9D2D, 0xE7D5, 0x9EFC -> out_ok=0. With the macro defined, err_cnt=2 after both frames.
- Backpressure: good frame with out_ready=0 for 5 cycles -> out_valid and out_data stable and in_ready=0 throughout. Frame transfer on the first out_ready=1 cycle; in_ready=1 on the following cycle.
- Resync: 0x1234, then 0x9D2D with in_sof=1, then 0xC3D5, 0x9EFC -> exactly one frame, out_data=0x9D2DC3D59EFC, out_ok=1.
- Reset mid-frame: assert rst after 2 words, release, then send the good frame -> no frame from the aborted words; the good frame is delivered with out_ok=1. Outputs are 0 during reset.
- Gapped input: good frame with in_valid low for 2 cycles between each word -> identical result to the first test; no transfer on in_valid=0 cycles.

Source files
------------

// File: rtl/checksum_rx_ctrl_if.sv
// Word-in / frame-out valid/ready bundle for the checksum receive controller.
// master drives words and accepts frames; slave is the controller.
interface checksum_rx_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int WORDS = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_word;
  logic                   in_sof;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORDS*WIDTH-1:0] out_data;
  logic                   out_ok;

  modport master (
    output in_valid, in_word, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_ok
  );

  modport slave (
    input  in_valid, in_word, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_ok
  );
endinterface

// File: rtl/checksum_rx_ctrl.sv
// Incremental ones'-complement frame checker with valid/ready framing.
// Optional CHECKSUM_RX_CTRL_ERR_CNT_EN adds a saturating bad-frame counter.
module checksum_rx_ctrl #(
  parameter int WIDTH = 16,
  parameter int WORDS = 3
) (
  input  logic clk,
  input  logic rst,
  checksum_rx_ctrl_if.slave bus
`ifdef CHECKSUM_RX_CTRL_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);
  localparam int DW = WORDS * WIDTH;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [DW-1:0]    data_q, data_d;
  logic             ok_q, ok_d;

  logic             xfer_in;
  logic             xfer_out;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] fold;

  assign xfer_in  = bus.in_valid & bus.in_ready;
  assign xfer_out = bus.out_valid & bus.out_ready;

  // End-around carry: one fold suffices for a two-operand add
  assign wide = {1'b0, sum_q} + {1'b0, bus.in_word};
  assign fold = wide[WIDTH-1:0]
              + {{(WIDTH-1){1'b0}}, wide[WIDTH]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    data_d  = data_q;
    ok_d    = ok_q;
    unique case (state_q)
      IDLE: begin
        if (xfer_in) begin
          data_d  = DW'(bus.in_word);
          sum_d   = bus.in_word;
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (xfer_in) begin
          if (bus.in_sof) begin
            data_d = DW'(bus.in_word);
            sum_d  = bus.in_word;
            cnt_d  = CW'(1);
          end else begin
            data_d = {data_q[DW-WIDTH-1:0], bus.in_word};
            sum_d  = fold;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WORDS - 1)) begin
              ok_d    = (fold == {WIDTH{1'b1}});
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (xfer_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_ok    = (state_q == HOLD) & ok_q;
  assign bus.out_data  = data_q;

`ifdef CHECKSUM_RX_CTRL_ERR_CNT_EN
  logic [15:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (xfer_out && !ok_q && err_q != 16'hFFFF)
      err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif

endmodule
